wb_uart_tx: RTL

Wishbone classic slave UART transmitter on the CPU data/instruction bus, downstream of the `cpu` master. Accepts bytes via memory-mapped writes into a TX FIFO, serialises them as 8N1 frames on `tx_o` at a programmable bit rate, and exposes status and divisor registers. Upper address decode is done by the interconnect; this block decodes `adr_i[3:2]` only.

---
 rtl/wb_uart_tx_if.sv | 23 ++
 rtl/wb_uart_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic bus bundle between the CPU-side master and the UART TX slave.
interface wb_uart_tx_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave UART transmitter: TX FIFO, 8N1 serializer with
// programmable bit period (DIVISOR+1 clocks), STATUS and DIVISOR registers.
module wb_uart_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd216
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wb_uart_tx_if.slave     bus,
  output logic            tx_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Bus-side registers
  logic        r_ack;
  logic [31:0] r_dat_o;
  logic        r_ovf;
  logic [15:0] r_div;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Serializer state
  logic [1:0]  r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;

  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_adr;
  logic        w_full;
  logic        w_empty;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;
  logic        w_busy;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused;

  // A request is taken only when ack is low, forcing a one-cycle gap between acks.
  assign w_req      = bus.stb_i & bus.cyc_i & ~r_ack;
  assign w_wr       = w_req & bus.we_i;
  assign w_rd       = w_req & ~bus.we_i;
  assign w_adr      = bus.adr_i[3:2];

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = w_wr & (w_adr == 2'd0) & bus.sel_i[0];
  assign w_push     = w_push_req & ~w_full;

  // The serializer takes a byte whenever it is idle or finishing a stop bit.
  assign w_bit_end  = (r_timer == 16'd0);
  assign w_pop      = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  assign w_busy     = (r_state != S_IDLE);
  assign w_head     = r_mem[r_rptr];

  assign bus.ack_o  = r_ack;
  assign bus.dat_o  = r_dat_o;
  assign bus.err_o  = 1'b0;
  assign bus.rty_o  = 1'b0;

  // Address bits above the register window and unused data lanes.
  assign w_unused   = ^{bus.adr_i[31:4], bus.adr_i[1:0], bus.dat_i[31:16], bus.sel_i[3:2]};

  // Assemble the STATUS word from pre-edge state
  always_comb begin
    w_status         = '0;
    w_status[0]      = w_full;
    w_status[1]      = w_empty;
    w_status[2]      = w_busy;
    w_status[3]      = r_ovf;
    w_status[8 +: CW] = r_count;
  end

  // Acknowledge and registered read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack   <= w_req;
      r_dat_o <= '0;
      if (w_rd) begin
        case (w_adr)
          2'd1:    r_dat_o <= w_status;
          2'd2:    r_dat_o <= {16'd0, r_div};
          default: r_dat_o <= '0;
        endcase
      end
    end
  end

  // DIVISOR lanes and sticky OVERFLOW flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && w_adr == 2'd2) begin
        if (bus.sel_i[0]) r_div[7:0]  <= bus.dat_i[7:0];
        if (bus.sel_i[1]) r_div[15:8] <= bus.dat_i[15:8];
      end
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && w_adr == 2'd1 && bus.sel_i[0] && bus.dat_i[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; a push while full is dropped even if a pop frees a slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage array (no reset so it maps onto RAM)
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= bus.dat_i[7:0];
  end

  // Serializer: timer reloads from DIVISOR at every bit boundary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift   <= w_head;
            r_timer   <= r_div;
            r_bit_idx <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer   <= r_div;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= r_div;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift   <= w_head;
              r_timer   <= r_div;
              r_bit_idx <= '0;
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
      endcase
    end
  end

  // Line level decoded from serializer state; idle and stop are mark (1)
  always_comb begin
    tx_o = 1'b1;
    case (r_state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = r_shift[0];
      default: tx_o = 1'b1;
    endcase
  end

endmodule
